// File: rtl/pong_pkg.sv
// Shared types and screen geometry for the pong datapath blocks.
package pong_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      POINT = 3'd3,
      OVER  = 3'd4
   } game_state_t;

   localparam int MIN_X = 0;
   localparam int MAX_X = 639;
   localparam int MIN_Y = 0;
   localparam int MAX_Y = 479;

   localparam int DEFAULT_BIT_WIDTH = 10;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Control bundle between the game-flow controller and the rest of the pong top level.
interface pong_game_ctrl_if #(
   parameter int BIT_WIDTH   = pong_pkg::DEFAULT_BIT_WIDTH,
   parameter int SCORE_WIDTH = 4
);
   logic                    frame_tick;
   logic                    start;
   logic [BIT_WIDTH:0]      ball_x;
   pong_pkg::game_state_t   state;
   logic                    ball_en;
   logic                    ball_rst;
   logic                    paddle_en;
   logic                    serve_dir;
   logic [SCORE_WIDTH-1:0]  p1_score;
   logic [SCORE_WIDTH-1:0]  p2_score;
   logic [1:0]              winner;

   modport master (
      output frame_tick, start, ball_x,
      input  state, ball_en, ball_rst, paddle_en, serve_dir, p1_score, p2_score, winner
   );

   modport slave (
      input  frame_tick, start, ball_x,
      output state, ball_en, ball_rst, paddle_en, serve_dir, p1_score, p2_score, winner
   );
endinterface

// File: rtl/phase_timer.sv
// Loadable frame-tick down-counter with a registered zero flag; used to time the
// SERVE and POINT phases.
module phase_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             zero_o
);
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             zero_q;
   logic             zero_d;

   // Next count: a load wins over a tick, and the count parks at zero.
   always_comb begin
      cnt_d  = cnt_q;
      zero_d = zero_q;
      if (load_i) begin
         cnt_d  = load_val_i;
         zero_d = (load_val_i == {CNT_W{1'b0}});
      end else if (tick_i && !zero_q) begin
         cnt_d  = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
         zero_d = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});
      end else begin
         cnt_d  = cnt_q;
         zero_d = zero_q;
      end
   end

   // Counter and zero flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= {CNT_W{1'b0}};
         zero_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         zero_q <= zero_d;
      end
   end

   assign zero_o = zero_q;
endmodule

// File: rtl/pong_game_ctrl.sv
// Game-flow controller: sequences serve/play/point/game-over, detects goals
// from ball_x on frame ticks and keeps both scores and the winner.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int BIT_WIDTH   = DEFAULT_BIT_WIDTH,
   parameter int SCORE_WIDTH = 4,
   parameter int WIN_SCORE   = 7,
   parameter int SERVE_DELAY = 60,
   parameter int POINT_HOLD  = 30,
   parameter int LEFT_GOAL   = 4,
   parameter int RIGHT_GOAL  = 635
) (
   input logic            clk,
   input logic            rst,
   pong_game_ctrl_if.slave bus
);
   localparam int MAX_DELAY = (SERVE_DELAY > POINT_HOLD) ? SERVE_DELAY : POINT_HOLD;
   localparam int CNT_W     = $clog2(MAX_DELAY + 1);

   localparam logic [CNT_W-1:0]       SERVE_LOAD = CNT_W'(SERVE_DELAY - 1);
   localparam logic [CNT_W-1:0]       POINT_LOAD = CNT_W'(POINT_HOLD - 1);
   localparam logic [SCORE_WIDTH-1:0] WIN_C      = SCORE_WIDTH'(WIN_SCORE);
   localparam logic [SCORE_WIDTH-1:0] ONE_C      = SCORE_WIDTH'(1);
   localparam logic [BIT_WIDTH:0]     LEFT_C     = (BIT_WIDTH+1)'(LEFT_GOAL);
   localparam logic [BIT_WIDTH:0]     RIGHT_C    = (BIT_WIDTH+1)'(RIGHT_GOAL);

   game_state_t             state_q, state_d;
   logic [SCORE_WIDTH-1:0]  p1_q, p1_d, p2_q, p2_d;
   logic [1:0]              winner_q, winner_d;
   logic                    serve_dir_q, serve_dir_d;
   logic                    ball_en_q, ball_en_d;
   logic                    ball_rst_q, ball_rst_d;
   logic                    paddle_en_q, paddle_en_d;

   logic                    load_s;
   logic [CNT_W-1:0]        load_val_s;
   logic                    tick_s;
   logic                    zero_s;
   logic [SCORE_WIDTH-1:0]  p1_inc_s;
   logic [SCORE_WIDTH-1:0]  p2_inc_s;

   assign p1_inc_s = p1_q + ONE_C;
   assign p2_inc_s = p2_q + ONE_C;
   // Only timed phases consume ticks, so the tick that enters a phase never counts.
   assign tick_s   = bus.frame_tick && ((state_q == SERVE) || (state_q == POINT));

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .tick_i     (tick_s),
      .load_i     (load_s),
      .load_val_i (load_val_s),
      .zero_o     (zero_s)
   );

   // Next-state, score and timer-load logic.
   always_comb begin
      state_d     = state_q;
      p1_d        = p1_q;
      p2_d        = p2_q;
      winner_d    = winner_q;
      serve_dir_d = serve_dir_q;
      load_s      = 1'b0;
      load_val_s  = SERVE_LOAD;
      case (state_q)
         IDLE, OVER: begin
            if (bus.start) begin
               state_d  = SERVE;
               p1_d     = {SCORE_WIDTH{1'b0}};
               p2_d     = {SCORE_WIDTH{1'b0}};
               winner_d = 2'd0;
               load_s   = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         SERVE: begin
            if (bus.frame_tick && zero_s) begin
               state_d = PLAY;
            end else begin
               state_d = SERVE;
            end
         end
         PLAY: begin
            // Left goal is checked first so it wins if both compares hit.
            if (bus.frame_tick && (bus.ball_x <= LEFT_C)) begin
               p2_d        = p2_inc_s;
               serve_dir_d = 1'b0;
               if (p2_inc_s == WIN_C) begin
                  state_d  = OVER;
                  winner_d = 2'd2;
               end else begin
                  state_d    = POINT;
                  load_s     = 1'b1;
                  load_val_s = POINT_LOAD;
               end
            end else if (bus.frame_tick && (bus.ball_x >= RIGHT_C)) begin
               p1_d        = p1_inc_s;
               serve_dir_d = 1'b1;
               if (p1_inc_s == WIN_C) begin
                  state_d  = OVER;
                  winner_d = 2'd1;
               end else begin
                  state_d    = POINT;
                  load_s     = 1'b1;
                  load_val_s = POINT_LOAD;
               end
            end else begin
               state_d = PLAY;
            end
         end
         POINT: begin
            if (bus.frame_tick && zero_s) begin
               state_d = SERVE;
               load_s  = 1'b1;
            end else begin
               state_d = POINT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Moore decode of the upcoming state so the enables register alongside it.
   always_comb begin
      ball_en_d   = 1'b0;
      ball_rst_d  = 1'b1;
      paddle_en_d = 1'b0;
      case (state_d)
         SERVE: begin
            ball_rst_d  = 1'b1;
            paddle_en_d = 1'b1;
         end
         PLAY: begin
            ball_en_d   = 1'b1;
            ball_rst_d  = 1'b0;
            paddle_en_d = 1'b1;
         end
         POINT: begin
            ball_rst_d  = 1'b0;
         end
         default: begin
            ball_en_d   = 1'b0;
            ball_rst_d  = 1'b1;
            paddle_en_d = 1'b0;
         end
      endcase
   end

   // State, score and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         p1_q        <= {SCORE_WIDTH{1'b0}};
         p2_q        <= {SCORE_WIDTH{1'b0}};
         winner_q    <= 2'd0;
         serve_dir_q <= 1'b0;
         ball_en_q   <= 1'b0;
         ball_rst_q  <= 1'b1;
         paddle_en_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         p1_q        <= p1_d;
         p2_q        <= p2_d;
         winner_q    <= winner_d;
         serve_dir_q <= serve_dir_d;
         ball_en_q   <= ball_en_d;
         ball_rst_q  <= ball_rst_d;
         paddle_en_q <= paddle_en_d;
      end
   end

   assign bus.state     = state_q;
   assign bus.p1_score  = p1_q;
   assign bus.p2_score  = p2_q;
   assign bus.winner    = winner_q;
   assign bus.serve_dir = serve_dir_q;
   assign bus.ball_en   = ball_en_q;
   assign bus.ball_rst  = ball_rst_q;
   assign bus.paddle_en = paddle_en_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed walk through a full game, then random
// start/tick/ball_x traffic checked against a phase-and-tick-count model.
module tb_pong_game_ctrl;
   localparam int BW  = 10;
   localparam int SW  = 4;
   localparam int WIN = 2;
   localparam int SD  = 3;
   localparam int PH  = 2;
   localparam int LG  = 4;
   localparam int RG  = 635;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   // Model: phase 0 idle, 1 serve, 2 play, 3 point, 4 over.
   int m_phase, m_ticks, m_p1, m_p2, m_win, m_dir;

   pong_game_ctrl_if #(.BIT_WIDTH(BW), .SCORE_WIDTH(SW)) bus_if ();

   pong_game_ctrl #(
      .BIT_WIDTH(BW), .SCORE_WIDTH(SW), .WIN_SCORE(WIN), .SERVE_DELAY(SD),
      .POINT_HOLD(PH), .LEFT_GOAL(LG), .RIGHT_GOAL(RG)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_phase = 0; m_ticks = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0;
   endfunction

   function automatic void model_clock(input bit st, input bit tk, input int x);
      case (m_phase)
         0, 4: if (st) begin
            m_phase = 1; m_ticks = 0; m_p1 = 0; m_p2 = 0; m_win = 0;
         end
         1: if (tk) begin
            m_ticks++;
            if (m_ticks == SD) begin m_phase = 2; m_ticks = 0; end
         end
         2: if (tk) begin
            if (x <= LG) begin
               m_p2++; m_dir = 0;
               if (m_p2 == WIN) begin m_phase = 4; m_win = 2; end
               else begin m_phase = 3; m_ticks = 0; end
            end else if (x >= RG) begin
               m_p1++; m_dir = 1;
               if (m_p1 == WIN) begin m_phase = 4; m_win = 1; end
               else begin m_phase = 3; m_ticks = 0; end
            end
         end
         3: if (tk) begin
            m_ticks++;
            if (m_ticks == PH) begin m_phase = 1; m_ticks = 0; end
         end
         default: m_phase = 0;
      endcase
   endfunction

   task automatic check_outputs(input string tag);
      check_val({tag, ".state"},     32'(bus_if.state), m_phase);
      check_val({tag, ".ball_en"},   32'(bus_if.ball_en), (m_phase == 2) ? 1 : 0);
      check_val({tag, ".ball_rst"},  32'(bus_if.ball_rst),
                (m_phase == 0 || m_phase == 1 || m_phase == 4) ? 1 : 0);
      check_val({tag, ".paddle_en"}, 32'(bus_if.paddle_en), (m_phase == 1 || m_phase == 2) ? 1 : 0);
      check_val({tag, ".serve_dir"}, 32'(bus_if.serve_dir), m_dir);
      check_val({tag, ".p1_score"},  32'(bus_if.p1_score), m_p1);
      check_val({tag, ".p2_score"},  32'(bus_if.p2_score), m_p2);
      check_val({tag, ".winner"},    32'(bus_if.winner), m_win);
   endtask

   task automatic step(input bit st, input bit tk, input int x, input string tag);
      @(negedge clk);
      bus_if.start      = st;
      bus_if.frame_tick = tk;
      bus_if.ball_x     = (BW+1)'(x);
      @(posedge clk);
      model_clock(st, tk, x);
      #1;
      check_outputs(tag);
   endtask

   // Pulse rst between clock edges and check the outputs drop without a clock.
   task automatic async_reset(input string tag);
      #2;
      bus_if.start      = 1'b0;
      bus_if.frame_tick = 1'b0;
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic ticks(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 320, tag);
   endtask

   initial begin
      rst = 1'b1;
      bus_if.start      = 1'b0;
      bus_if.frame_tick = 1'b0;
      bus_if.ball_x     = (BW+1)'(320);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      ticks(5, "idle_ticks");
      check_val("idle_hold", 32'(bus_if.state), 0);
      step(1'b1, 1'b0, 320, "start");
      check_val("start_serve", 32'(bus_if.state), 1);
      ticks(2, "serve");
      check_val("serve_not_yet", 32'(bus_if.state), 1);
      ticks(1, "serve_end");
      check_val("play_ball_en", 32'(bus_if.ball_en), 1);

      step(1'b0, 1'b1, 3, "goal_left");
      check_val("goal_left_p2", 32'(bus_if.p2_score), 1);
      ticks(PH, "point");
      check_val("point_to_serve", 32'(bus_if.state), 1);
      ticks(SD, "serve2");

      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 636, "x_no_tick");
      step(1'b0, 1'b1, 636, "goal_right");
      check_val("goal_right_dir", 32'(bus_if.serve_dir), 1);
      ticks(PH, "point2");
      ticks(SD, "serve3");
      step(1'b0, 1'b1, 639, "win_p1");
      check_val("win_p1_winner", 32'(bus_if.winner), 1);
      step(1'b0, 1'b1, 320, "over_hold");

      step(1'b1, 1'b1, 320, "restart");
      check_val("restart_score", 32'(bus_if.p1_score), 0);
      ticks(SD, "serve4");
      step(1'b0, 1'b1, 637, "goal_right2");
      ticks(PH, "point3");
      ticks(SD, "serve5");
      check_val("mid_play_p1", 32'(bus_if.p1_score), 1);
      async_reset("async_rst");
      ticks(3, "post_rst_idle");

      for (int n = 0; n < 3000; n++) begin
         int r;
         int x;
         bit st;
         bit tk;
         st = ($urandom_range(0, 7) == 0);
         tk = ($urandom_range(0, 2) == 0);
         r  = $urandom_range(0, 3);
         if (r == 0)      x = $urandom_range(0, LG);
         else if (r == 1) x = $urandom_range(RG, 639);
         else             x = $urandom_range(LG + 1, RG - 1);
         step(st, tk, x, "rand");
         if ($urandom_range(0, 399) == 0) async_reset("rand_rst");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
